// File: rtl/term_sum_sequencer.sv
// Sums NUM_TERMS evaluator results through the shared FP adder, one term at a time,
// with a per-handshake watchdog that aborts a stalled evaluation.
//   state       | meaning
//   IDLE        | waiting for eval_start, sum_value held
//   START_TERM  | term_accumulator_start high, watchdog cleared
//   WAIT_TERM   | waiting for term_ready (watchdog running)
//   START_ADD   | load adder operands, issue add_start
//   WAIT_ADD    | waiting for add_data_ready (watchdog running)
//   NEXT        | advance term_index or finish
//   DONE        | publish sum_value, pulse sum_ready
//   ABORT       | flag timeout_error, keep previous sum_value
module term_sum_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_TERMS      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              eval_start,
    output logic                                              term_accumulator_start,
    output logic [$clog2(NUM_TERMS > 1 ? NUM_TERMS : 2)-1:0]  term_index,
    input  logic [DATA_WIDTH-1:0]                             term_value,
    input  logic                                              term_ready,
    output logic                                              add_start,
    output logic [DATA_WIDTH-1:0]                             add_operand_a,
    output logic [DATA_WIDTH-1:0]                             add_operand_b,
    input  logic [DATA_WIDTH-1:0]                             add_result,
    input  logic                                              add_data_ready,
    output logic [DATA_WIDTH-1:0]                             sum_value,
    output logic                                              sum_ready,
    output logic                                              busy,
    output logic                                              timeout_error
);

    localparam int IDX_W = $clog2(NUM_TERMS > 1 ? NUM_TERMS : 2);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TERMS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_TERM,
        S_WAIT_TERM,
        S_START_ADD,
        S_WAIT_ADD,
        S_NEXT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        term_index_q, term_index_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;
    logic [DATA_WIDTH-1:0]   run_sum_q, run_sum_d;
    logic [DATA_WIDTH-1:0]   add_operand_a_q, add_operand_a_d;
    logic [DATA_WIDTH-1:0]   add_operand_b_q, add_operand_b_d;
    logic [DATA_WIDTH-1:0]   sum_value_q, sum_value_d;
    logic                    term_start_q, term_start_d;
    logic                    add_start_q, add_start_d;
    logic                    sum_ready_q, sum_ready_d;
    logic                    busy_q, busy_d;
    logic                    timeout_error_q, timeout_error_d;

    always_comb begin
        state_d         = state_q;
        term_index_d    = term_index_q;
        wdog_d          = wdog_q;
        run_sum_d       = run_sum_q;
        add_operand_a_d = add_operand_a_q;
        add_operand_b_d = add_operand_b_q;
        sum_value_d     = sum_value_q;
        term_start_d    = 1'b0;
        add_start_d     = 1'b0;
        sum_ready_d     = 1'b0;
        busy_d          = busy_q;
        timeout_error_d = timeout_error_q;

        unique case (state_q)
            S_IDLE: begin
                if (eval_start) begin
                    run_sum_d       = '0;
                    term_index_d    = '0;
                    timeout_error_d = 1'b0;
                    busy_d          = 1'b1;
                    term_start_d    = 1'b1;
                    state_d         = S_START_TERM;
                end
            end
            S_START_TERM: begin
                wdog_d  = '0;
                state_d = S_WAIT_TERM;
            end
            S_WAIT_TERM: begin
                // A ready on the limit cycle takes priority over the abort.
                if (term_ready) begin
                    add_operand_b_d = term_value;
                    state_d         = S_START_ADD;
                end else if (wdog_q == WD_LIMIT) begin
                    state_d = S_ABORT;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_START_ADD: begin
                // add_start appears together with the freshly loaded operand A.
                add_operand_a_d = run_sum_q;
                add_start_d     = 1'b1;
                wdog_d          = '0;
                state_d         = S_WAIT_ADD;
            end
            S_WAIT_ADD: begin
                if (add_data_ready) begin
                    run_sum_d = add_result;
                    state_d   = S_NEXT;
                end else if (wdog_q == WD_LIMIT) begin
                    state_d = S_ABORT;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_NEXT: begin
                if (term_index_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    term_index_d = term_index_q + IDX_W'(1);
                    term_start_d = 1'b1;
                    state_d      = S_START_TERM;
                end
            end
            S_DONE: begin
                sum_value_d = run_sum_q;
                sum_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            S_ABORT: begin
                timeout_error_d = 1'b1;
                busy_d          = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            term_index_q    <= '0;
            wdog_q          <= '0;
            run_sum_q       <= '0;
            add_operand_a_q <= '0;
            add_operand_b_q <= '0;
            sum_value_q     <= '0;
            term_start_q    <= 1'b0;
            add_start_q     <= 1'b0;
            sum_ready_q     <= 1'b0;
            busy_q          <= 1'b0;
            timeout_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            term_index_q    <= term_index_d;
            wdog_q          <= wdog_d;
            run_sum_q       <= run_sum_d;
            add_operand_a_q <= add_operand_a_d;
            add_operand_b_q <= add_operand_b_d;
            sum_value_q     <= sum_value_d;
            term_start_q    <= term_start_d;
            add_start_q     <= add_start_d;
            sum_ready_q     <= sum_ready_d;
            busy_q          <= busy_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    assign term_accumulator_start = term_start_q;
    assign term_index             = term_index_q;
    assign add_start              = add_start_q;
    assign add_operand_a          = add_operand_a_q;
    assign add_operand_b          = add_operand_b_q;
    assign sum_value              = sum_value_q;
    assign sum_ready              = sum_ready_q;
    assign busy                   = busy_q;
    assign timeout_error          = timeout_error_q;

endmodule

// File: tb/tb_term_sum_sequencer.sv
// Directed bench: behavioural evaluator/adder models around a 4-term and a 1-term sequencer.
module tb_term_sum_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int tests_run    = 0;
    int tests_failed = 0;

    // 4-term instance
    logic        eval_start4 = 1'b0;
    logic        term_start4;
    logic [1:0]  term_index4;
    logic [31:0] term_value4 = 32'h0;
    logic        term_ready4 = 1'b0;
    logic        add_start4;
    logic [31:0] add_operand_a4, add_operand_b4;
    logic [31:0] add_result4 = 32'h0;
    logic        add_data_ready4 = 1'b0;
    logic [31:0] sum_value4;
    logic        sum_ready4, busy4, timeout_error4;

    // 1-term instance
    logic        eval_start1 = 1'b0;
    logic        term_start1;
    logic [0:0]  term_index1;
    logic [31:0] term_value1 = 32'h0;
    logic        term_ready1 = 1'b0;
    logic        add_start1;
    logic [31:0] add_operand_a1, add_operand_b1;
    logic [31:0] add_result1 = 32'h0;
    logic        add_data_ready1 = 1'b0;
    logic [31:0] sum_value1;
    logic        sum_ready1, busy1, timeout_error1;

    term_sum_sequencer #(.DATA_WIDTH(32), .NUM_TERMS(4), .TIMEOUT_CYCLES(16)) dut4 (
        .clock(clock), .reset(reset), .eval_start(eval_start4),
        .term_accumulator_start(term_start4), .term_index(term_index4),
        .term_value(term_value4), .term_ready(term_ready4),
        .add_start(add_start4), .add_operand_a(add_operand_a4), .add_operand_b(add_operand_b4),
        .add_result(add_result4), .add_data_ready(add_data_ready4),
        .sum_value(sum_value4), .sum_ready(sum_ready4), .busy(busy4), .timeout_error(timeout_error4)
    );

    term_sum_sequencer #(.DATA_WIDTH(32), .NUM_TERMS(1), .TIMEOUT_CYCLES(16)) dut1 (
        .clock(clock), .reset(reset), .eval_start(eval_start1),
        .term_accumulator_start(term_start1), .term_index(term_index1),
        .term_value(term_value1), .term_ready(term_ready1),
        .add_start(add_start1), .add_operand_a(add_operand_a1), .add_operand_b(add_operand_b1),
        .add_result(add_result1), .add_data_ready(add_data_ready1),
        .sum_value(sum_value1), .sum_ready(sum_ready1), .busy(busy1), .timeout_error(timeout_error1)
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // Hand-computed single-precision sums for the operand pairs this bench produces.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h0000_0000, 32'h3F80_0000}: return 32'h3F80_0000;
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h4040_0000, 32'h4040_0000}: return 32'h40C0_0000;
            {32'h40C0_0000, 32'h4080_0000}: return 32'h4120_0000;
            {32'h0000_0000, 32'hC000_0000}: return 32'hC000_0000;
            default:                        return 32'h7FC0_0000;
        endcase
    endfunction

    // model controls and observations (4-term)
    int          lt = 5, la = 3, drop = -1;
    bit          spur = 1'b0;
    int          tcnt4 = 0, acnt4 = 0;
    logic [31:0] tpend4 = 32'h0, apend4 = 32'h0;
    int          tstarts4 = 0, astarts4 = 0, srcnt4 = 0;
    logic [7:0]  idx_log = 8'h0;
    logic [31:0] last_a4 = 32'h0, last_b4 = 32'h0;
    logic [31:0] terms [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

    initial forever begin
        @(negedge clock);
        term_ready4     = 1'b0;
        add_data_ready4 = 1'b0;
        term_value4     = 32'h7F80_0001;
        add_result4     = 32'h7F80_0001;
        if (reset) begin
            tcnt4 = 0;
            acnt4 = 0;
        end else begin
            if (tcnt4 > 0) begin
                tcnt4 = tcnt4 - 1;
                if (tcnt4 == 0) begin
                    term_ready4 = 1'b1;
                    term_value4 = tpend4;
                end else if (spur) begin
                    add_data_ready4 = 1'b1;
                    add_result4     = 32'h4F00_0000;
                end
            end
            if (acnt4 > 0) begin
                acnt4 = acnt4 - 1;
                if (acnt4 == 0) begin
                    add_data_ready4 = 1'b1;
                    add_result4     = apend4;
                end else if (spur) begin
                    term_ready4 = 1'b1;
                    term_value4 = 32'h4F00_0000;
                end
            end
            if (term_start4) begin
                tstarts4 = tstarts4 + 1;
                idx_log  = {idx_log[5:0], term_index4};
                if (int'(term_index4) != drop) begin
                    tcnt4  = lt;
                    tpend4 = terms[term_index4];
                end
            end
            if (add_start4) begin
                astarts4 = astarts4 + 1;
                last_a4  = add_operand_a4;
                last_b4  = add_operand_b4;
                acnt4    = la;
                apend4   = fadd(add_operand_a4, add_operand_b4);
            end
            if (sum_ready4) srcnt4 = srcnt4 + 1;
        end
    end

    // 1-term models: Lt=2, La=2, term value -2.0
    int          tcnt1 = 0, acnt1 = 0, astarts1 = 0;
    logic [31:0] apend1 = 32'h0, last_a1 = 32'h0, last_b1 = 32'h0;

    initial forever begin
        @(negedge clock);
        term_ready1     = 1'b0;
        add_data_ready1 = 1'b0;
        term_value1     = 32'h7F80_0001;
        add_result1     = 32'h7F80_0001;
        if (reset) begin
            tcnt1 = 0;
            acnt1 = 0;
        end else begin
            if (tcnt1 > 0) begin
                tcnt1 = tcnt1 - 1;
                if (tcnt1 == 0) begin
                    term_ready1 = 1'b1;
                    term_value1 = 32'hC000_0000;
                end
            end
            if (acnt1 > 0) begin
                acnt1 = acnt1 - 1;
                if (acnt1 == 0) begin
                    add_data_ready1 = 1'b1;
                    add_result1     = apend1;
                end
            end
            if (term_start1) tcnt1 = 2;
            if (add_start1) begin
                astarts1 = astarts1 + 1;
                last_a1  = add_operand_a1;
                last_b1  = add_operand_b1;
                acnt1    = 2;
                apend1   = fadd(add_operand_a1, add_operand_b1);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run = tests_run + 1;
        assert (obs === exp) else begin
            tests_failed = tests_failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses eval_start, then waits (bounded) for busy to drop; lat counts cycles from eval_start.
    task automatic run_eval(input bit one, input int budget, input int restart_at,
                            output int lat, output logic ok, output logic sr);
        int c0;
        @(negedge clock);
        eval_start4 = !one;
        eval_start1 = one;
        c0  = cyc;
        ok  = 1'b0;
        sr  = 1'b0;
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            eval_start4 = !one && (i == restart_at);
            eval_start1 = one && (i == restart_at);
            if (!(one ? busy1 : busy4)) begin
                lat = cyc - c0;
                ok  = 1'b1;
                sr  = one ? sum_ready1 : sum_ready4;
                break;
            end
        end
        eval_start4 = 1'b0;
        eval_start1 = 1'b0;
    endtask

    int   lat, ts0, as0, sr0;
    logic ok, sr;

    initial begin
        repeat (3) @(negedge clock);
        check("reset_busy", 64'(busy4), 64'h0);
        check("reset_outputs", 64'({sum_ready4, timeout_error4, term_start4, add_start4, term_index4}), 64'h0);
        check("reset_sum", 64'(sum_value4), 64'h0);
        reset = 1'b0;
        @(negedge clock);

        // A: 1+2+3+4 with a redundant eval_start mid-evaluation
        ts0 = tstarts4; as0 = astarts4; sr0 = srcnt4;
        run_eval(1'b0, 200, 20, lat, ok, sr);
        check("A_done", 64'(ok), 64'h1);
        check("A_latency", 64'(lat), 64'd50);
        check("A_sum_ready", 64'(sr), 64'h1);
        check("A_sum", 64'(sum_value4), 64'h4120_0000);
        @(negedge clock);
        check("A_term_starts", 64'(tstarts4 - ts0), 64'd4);
        check("A_add_starts", 64'(astarts4 - as0), 64'd4);
        check("A_sum_ready_pulses", 64'(srcnt4 - sr0), 64'd1);
        check("A_index_seq", 64'(idx_log), 64'h1B);
        check("A_last_ops", 64'({last_a4, last_b4}), 64'h40C0_0000_4080_0000);
        check("A_busy_after", 64'(busy4), 64'h0);

        // B: spurious readies in the wrong wait states
        spur = 1'b1;
        run_eval(1'b0, 200, 0, lat, ok, sr);
        check("B_latency", 64'(lat), 64'd50);
        check("B_sum", 64'(sum_value4), 64'h4120_0000);
        spur = 1'b0;

        // C: term 2 never becomes ready -> abort
        drop = 2;
        sr0  = srcnt4;
        run_eval(1'b0, 200, 0, lat, ok, sr);
        check("C_abort_latency", 64'(lat), 64'd43);
        check("C_no_sum_ready", 64'(sr), 64'h0);
        check("C_timeout", 64'(timeout_error4), 64'h1);
        check("C_sum_kept", 64'(sum_value4), 64'h4120_0000);
        @(negedge clock);
        check("C_sum_ready_pulses", 64'(srcnt4 - sr0), 64'd0);
        drop = -1;

        // D: new start clears timeout, then reset while waiting on the adder
        @(negedge clock);
        eval_start4 = 1'b1;
        @(negedge clock);
        eval_start4 = 1'b0;
        check("D_timeout_cleared", 64'({busy4, timeout_error4}), 64'h2);
        repeat (7) @(negedge clock);
        check("D_in_wait_add", 64'(add_start4), 64'h1);
        reset = 1'b1;
        @(negedge clock);
        check("D_reset_ctrl", 64'({busy4, sum_ready4, timeout_error4, term_start4, add_start4, term_index4}), 64'h0);
        check("D_reset_data", 64'({sum_value4, add_operand_a4}), 64'h0);
        check("D_reset_opb", 64'(add_operand_b4), 64'h0);
        reset = 1'b0;
        @(negedge clock);

        // E: fresh evaluation after reset
        run_eval(1'b0, 200, 0, lat, ok, sr);
        check("E_latency", 64'(lat), 64'd50);
        check("E_sum", 64'(sum_value4), 64'h4120_0000);
        check("E_timeout", 64'(timeout_error4), 64'h0);

        // F: both readies land on the watchdog-limit cycle
        lt = 16; la = 15;
        run_eval(1'b0, 400, 0, lat, ok, sr);
        check("F_latency", 64'(lat), 64'd142);
        check("F_timeout", 64'(timeout_error4), 64'h0);
        check("F_sum", 64'(sum_value4), 64'h4120_0000);

        // G: single-term instance, -2.0
        as0 = astarts1;
        run_eval(1'b1, 100, 0, lat, ok, sr);
        check("G_latency", 64'(lat), 64'd10);
        check("G_sum", 64'(sum_value1), 64'hC000_0000);
        @(negedge clock);
        check("G_add_starts", 64'(astarts1 - as0), 64'd1);
        check("G_ops", 64'({last_a1, last_b1}), 64'h0000_0000_C000_0000);
        check("G_timeout", 64'(timeout_error1), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/term_sum_sequencer.md
Name: term_sum_sequencer

Overview:
- Downstream consumer of the per-term postfix evaluator: issues one start per term, captures each finished term value, and folds it into a running sum.
- The running sum is built through the shared floating-point adder using a start/ready handshake.
- Produces the final expression value for the key-evaluation datapath, with a completion pulse.
- Watchdog aborts the evaluation if the term evaluator or adder stalls.

Parameters:
- DATA_WIDTH, 32, width of term values, adder operands and sum (IEEE-754 single).
- NUM_TERMS, 16, number of terms summed per evaluation (legal range 1..256).
- TIMEOUT_CYCLES, 4096, maximum wait cycles per handshake before abort (legal range ≥2).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- eval_start  input  1  one-cycle request to start a full evaluation
- term_accumulator_start  output  1  one-cycle pulse starting evaluation of the current term
- term_index  output  $clog2(NUM_TERMS) (min 1)  index of the term being evaluated
- term_value  input  DATA_WIDTH  finished term value from the evaluator
- term_ready  input  1  term_value valid this cycle
- add_start  output  1  one-cycle pulse to the shared adder
- add_operand_a  output  DATA_WIDTH  running sum
- add_operand_b  output  DATA_WIDTH  captured term value
- add_result  input  DATA_WIDTH  adder result
- add_data_ready  input  1  add_result valid this cycle
- sum_value  output  DATA_WIDTH  final sum, held until the next accepted eval_start
- sum_ready  output  1  one-cycle pulse when sum_value is updated
- busy  output  1  high from eval_start acceptance through DONE/ABORT
- timeout_error  output  1  sticky until the next accepted eval_start or reset

Behaviour:
- Reset: state IDLE; every output 0; internal running sum 32'h0000_0000, term counter 0, watchdog 0.
- States: IDLE, START_TERM, WAIT_TERM, START_ADD, WAIT_ADD, NEXT, DONE, ABORT.
- IDLE:
  - On eval_start: clear running sum to +0.0, term_index 0, timeout_error 0, busy 1, go to START_TERM.
  - Otherwise hold; sum_value is retained.
- START_TERM: drive term_accumulator_start=1 for exactly one cycle; clear watchdog; go to WAIT_TERM.
- WAIT_TERM:
  - On term_ready: capture term_value into the operand_b register; go to START_ADD.
  - Otherwise increment watchdog; when watchdog reaches TIMEOUT_CYCLES-1, go to ABORT.
- START_ADD: add_operand_a=running sum, add_operand_b=captured term (both registered, stable until leaving WAIT_ADD); add_start=1 for one cycle; clear watchdog; go to WAIT_ADD.
- WAIT_ADD:
  - On add_data_ready: running sum <= add_result; go to NEXT.
  - Otherwise apply the same watchdog rule as WAIT_TERM.
- NEXT:
  - If term_index == NUM_TERMS-1, go to DONE.
  - Else term_index+1, go to START_TERM.
- DONE: sum_value <= running sum; sum_ready=1 for one cycle; busy deasserts the following cycle; go to IDLE.
- ABORT: timeout_error <= 1; sum_value unchanged; sum_ready stays 0; go to IDLE; busy 0 from the next cycle.
- Latency: with a term evaluator latency Lt and adder latency La (cycles from start to ready), the evaluation takes NUM_TERMS*(Lt+La+4)+2 cycles from eval_start to sum_ready.
- Handshake rules:
  - term_ready outside WAIT_TERM is ignored.
  - add_data_ready outside WAIT_ADD is ignored.
  - eval_start while busy is ignored; the evaluation is not restarted.
- Simultaneous events: ready arriving on the same cycle the watchdog hits its limit → ready wins and no abort occurs.
- The first term is added to +0.0, with no special case. NUM_TERMS=1 therefore yields exactly one add.
- Reset asserted mid-operation: next cycle is IDLE with all outputs 0. The sum_value register is also cleared.
- No arithmetic is performed internally; all summation goes through the adder.

Test Plan:
- NUM_TERMS=4, terms 1.0, 2.0, 3.0, 4.0 (3F800000, 40000000, 40400000, 40800000), behavioural adder La=3, evaluator Lt=5 → sum_value=41200000 (10.0), one sum_ready pulse at cycle 4*(5+3+4)+2=50, term_index sequence 0..3, four term_accumulator_start pulses.
- Spurious term_ready while in WAIT_ADD and spurious add_data_ready while in WAIT_TERM → ignored; result unchanged at 41200000.
- Evaluator never asserts term_ready on term 2, TIMEOUT_CYCLES=16 → ABORT, timeout_error=1, sum_ready never pulses, sum_value keeps the previous result, busy drops.
- eval_start reasserted mid-evaluation → ignored. Reset asserted during WAIT_ADD → all outputs 0 next cycle. A fresh eval_start then completes normally and clears timeout_error.
- NUM_TERMS=1, term C0000000 (-2.0) → exactly one add_start with operands 00000000 and C0000000; sum_value=C0000000.
- Ready asserted on the exact watchdog-limit cycle → no abort; evaluation completes.
